pad_reader: RTL and testbench
=============================

PAD_READER -- requirements
Module: pad_reader

Interface
REQ-001 Parameter CLKS_PER_HALF, default 300, meaning: clocks per half-period of pad_clk (6 us at 50 MHz); legal values >= 2.
REQ-002 clock  input  1  system clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_tick  input  1  one-cycle poll request (driven at end of frame).
REQ-005 dflt  input  1  game-default level; clears heading.
REQ-006 pad_data  input  1  serial button data from NES-style pad, active-low, pre-synchronized.
REQ-007 pad_latch  output  1  pad latch strobe, active-high.
REQ-008 pad_clk  output  1  pad shift clock, idle low.
REQ-009 p_info  output  4  one-hot heading: 0001 up, 0010 down, 0100 left, 1000 right, 0000 none.
REQ-010 buttons  output  8  last polled buttons, active-high, bit0..7 = A,B,Select,Start,Up,Down,Left,Right.
REQ-011 poll_done  output  1  one-cycle pulse when a poll completes.

Function
REQ-012 FSM states SHALL be IDLE, LATCH, CLK_HI, CLK_LO, DONE.
REQ-013 IDLE -> LATCH on frame_tick; frame_tick in any other state SHALL be ignored.
REQ-014 LATCH SHALL last 2*CLKS_PER_HALF cycles with pad_latch=1; bit0 sampled (inverted) on its last cycle.
REQ-015 For bits 1..7: CLK_HI lasts CLKS_PER_HALF cycles with pad_clk=1, then CLK_LO lasts CLKS_PER_HALF cycles with pad_clk=0; bit i sampled (inverted) on last cycle of the i-th CLK_LO.
REQ-016 After the 7th CLK_LO the FSM SHALL enter DONE for exactly one cycle, then IDLE.
REQ-017 Poll latency frame_tick -> poll_done SHALL be 16*CLKS_PER_HALF + 1 cycles (4801 at default).
REQ-018 pad_latch and pad_clk SHALL be registered outputs and never high simultaneously.
REQ-019 Shifted bits SHALL accumulate in a shadow register; buttons SHALL update only in DONE, never mid-poll.
REQ-020 poll_done SHALL be high in the cycle after DONE, coincident with the new buttons and p_info values.
REQ-021 Candidate direction from new buttons, priority Up > Down > Left > Right; none pressed = no candidate.
REQ-022 In DONE, heading SHALL take the candidate unless no candidate or candidate is the exact opposite of current heading (up/down, left/right), in which case heading holds.
REQ-023 From heading 0000 any candidate SHALL be accepted.
REQ-024 p_info SHALL always be 0000 or exactly one-hot.
REQ-025 dflt=1 SHALL force heading to 0000 on the next edge, overriding a simultaneous DONE update; buttons still update and polling continues.
REQ-026 Bit counter SHALL be 3 bits and phase counter wide enough for 2*CLKS_PER_HALF-1; neither SHALL wrap within a poll.

Reset
REQ-027 On reset: state IDLE, pad_latch=0, pad_clk=0, p_info=0000, buttons=00000000, poll_done=0, counters 0.
REQ-028 Reset asserted mid-poll SHALL abort the poll with no update to buttons or p_info.
REQ-029 Reset SHALL override frame_tick and dflt in the same cycle.

Verification
REQ-030 CLKS_PER_HALF=4, pad model all released (pad_data=1), frame_tick -> pad_latch high 8 cycles, seven 4-high/4-low pad_clk pulses, poll_done at cycle 65, buttons=00, p_info=0000.
REQ-031 Pad holds Up only -> buttons=00010000, p_info=0001; next poll with Down only -> p_info stays 0001; then Left only -> 0100.
REQ-032 Up+Left+Right pressed from heading 0000 -> p_info=0001 (priority); then Right only -> 1000.
REQ-033 frame_tick pulsed again at cycle 20 of a poll -> ignored, exactly one poll_done; dflt=1 during DONE with Left pressed -> p_info=0000, buttons=01000000.
REQ-034 Reset at cycle 30 of a poll with Right pressed -> pad_latch=pad_clk=0 next cycle, p_info and buttons unchanged at 0, no poll_done.
REQ-035 Over random stimulus: p_info one-hot-or-zero every cycle; pad_latch & pad_clk never 1 together.

Source files
------------

// File: rtl/pad_reader.sv
// NES-style controller poller: latches the pad, clocks out eight active-low button bits,
// then publishes the button byte and a heading that never reverses onto itself.
module pad_reader #(
    parameter int unsigned CLKS_PER_HALF = 300
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       dflt,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [3:0] p_info,
    output logic [7:0] buttons,
    output logic       poll_done
);

    localparam int unsigned PW = $clog2(2 * CLKS_PER_HALF);
    localparam logic [PW-1:0] LastLatch = PW'(2 * CLKS_PER_HALF - 1);
    localparam logic [PW-1:0] LastHalf  = PW'(CLKS_PER_HALF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StClkHi,
        StClkLo,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [PW-1:0] r_phase;
    logic [PW-1:0] w_phase_d;
    logic [2:0]  r_bit;
    logic [2:0]  w_bit_d;
    logic [7:0]  r_shadow;
    logic [7:0]  w_shadow_d;
    logic [7:0]  r_buttons;
    logic [7:0]  w_buttons_d;
    logic [3:0]  r_heading;
    logic [3:0]  w_heading_d;
    logic        r_pad_latch;
    logic        r_pad_clk;
    logic        r_poll_done;
    logic [3:0]  w_cand;
    logic [3:0]  w_opposite;
    logic        w_accept;

    // Candidate heading from the freshly shifted byte, Up > Down > Left > Right.
    always_comb begin
        w_cand = 4'b0000;
        if (r_shadow[4]) begin
            w_cand = 4'b0001;
        end else if (r_shadow[5]) begin
            w_cand = 4'b0010;
        end else if (r_shadow[6]) begin
            w_cand = 4'b0100;
        end else if (r_shadow[7]) begin
            w_cand = 4'b1000;
        end
    end

    // Swap up<->down and left<->right; zero heading has no opposite.
    assign w_opposite = {r_heading[2], r_heading[3], r_heading[0], r_heading[1]};
    assign w_accept   = (w_cand != 4'b0000) && (w_cand != w_opposite);

    always_comb begin
        w_state_d   = r_state;
        w_phase_d   = r_phase + 1'b1;
        w_bit_d     = r_bit;
        w_shadow_d  = r_shadow;
        w_buttons_d = r_buttons;
        w_heading_d = r_heading;
        unique case (r_state)
            StIdle: begin
                w_phase_d  = '0;
                w_bit_d    = '0;
                w_shadow_d = '0;
                if (frame_tick) begin
                    w_state_d = StLatch;
                end
            end
            StLatch: begin
                if (r_phase == LastLatch) begin
                    w_shadow_d[0] = ~pad_data;
                    w_bit_d       = 3'd1;
                    w_phase_d     = '0;
                    w_state_d     = StClkHi;
                end
            end
            StClkHi: begin
                if (r_phase == LastHalf) begin
                    w_phase_d = '0;
                    w_state_d = StClkLo;
                end
            end
            StClkLo: begin
                if (r_phase == LastHalf) begin
                    w_shadow_d[r_bit] = ~pad_data;
                    w_phase_d         = '0;
                    if (r_bit == 3'd7) begin
                        w_state_d = StDone;
                    end else begin
                        w_bit_d   = r_bit + 3'd1;
                        w_state_d = StClkHi;
                    end
                end
            end
            StDone: begin
                w_buttons_d = r_shadow;
                if (w_accept) begin
                    w_heading_d = w_cand;
                end
                w_phase_d = '0;
                w_bit_d   = '0;
                w_state_d = StIdle;
            end
            default: begin
                w_phase_d = '0;
                w_state_d = StIdle;
            end
        endcase
        if (dflt) begin
            w_heading_d = 4'b0000;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_phase     <= '0;
            r_bit       <= '0;
            r_shadow    <= '0;
            r_buttons   <= '0;
            r_heading   <= '0;
            r_pad_latch <= 1'b0;
            r_pad_clk   <= 1'b0;
            r_poll_done <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_phase     <= w_phase_d;
            r_bit       <= w_bit_d;
            r_shadow    <= w_shadow_d;
            r_buttons   <= w_buttons_d;
            r_heading   <= w_heading_d;
            // Strobes follow the next state so they line up exactly with the state they mark.
            r_pad_latch <= (w_state_d == StLatch);
            r_pad_clk   <= (w_state_d == StClkHi);
            r_poll_done <= (r_state == StDone);
        end
    end

    assign pad_latch = r_pad_latch;
    assign pad_clk   = r_pad_clk;
    assign p_info    = r_heading;
    assign buttons   = r_buttons;
    assign poll_done = r_poll_done;

endmodule

// File: tb/tb_pad_reader.sv
// Directed table of polls against a behavioural pad, plus reset corner cases and a random soak.
module tb_pad_reader;

    localparam int unsigned H = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       dflt = 1'b0;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic [3:0] p_info;
    logic [7:0] buttons;
    logic       poll_done;

    pad_reader #(.CLKS_PER_HALF(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .frame_tick (frame_tick),
        .dflt       (dflt),
        .pad_data   (pad_data),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .p_info     (p_info),
        .buttons    (buttons),
        .poll_done  (poll_done)
    );

    always #5 clock = ~clock;

    // Pad model: latch reloads bit 0, each rising pad_clk advances to the next bit.
    logic [7:0] pressed = 8'h00;
    logic [2:0] pad_idx = 3'd0;
    logic       pad_clk_q = 1'b0;
    always @(posedge clock) begin
        pad_clk_q <= pad_clk;
        if (pad_latch) pad_idx <= 3'd0;
        else if (pad_clk && !pad_clk_q) pad_idx <= pad_idx + 3'd1;
    end
    assign pad_data = ~pressed[pad_idx];

    int n_pass = 0;
    int n_total = 0;
    int viol = 0;
    logic mon_en = 1'b0;

    always @(negedge clock) begin
        if (mon_en) begin
            if (pad_latch && pad_clk) viol++;
            if ($countones(p_info) > 1) viol++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [7:0] pr;
        logic       dflt_v;
        logic       retick;
        logic [7:0] exp_btn;
        logic [3:0] exp_pinfo;
    } vec_t;

    vec_t vecs[15];
    logic [7:0] prev_btn = 8'h00;

    initial begin
        vecs[0]  = '{8'h00, 1'b0, 1'b0, 8'h00, 4'b0000};
        vecs[1]  = '{8'h10, 1'b0, 1'b0, 8'h10, 4'b0001};
        vecs[2]  = '{8'h20, 1'b0, 1'b0, 8'h20, 4'b0001};
        vecs[3]  = '{8'h40, 1'b0, 1'b0, 8'h40, 4'b0100};
        vecs[4]  = '{8'h80, 1'b0, 1'b0, 8'h80, 4'b0100};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 8'h00, 4'b0100};
        vecs[6]  = '{8'h03, 1'b0, 1'b0, 8'h03, 4'b0100};
        vecs[7]  = '{8'h20, 1'b0, 1'b0, 8'h20, 4'b0010};
        vecs[8]  = '{8'h10, 1'b0, 1'b0, 8'h10, 4'b0010};
        vecs[9]  = '{8'h40, 1'b1, 1'b1, 8'h40, 4'b0000};
        vecs[10] = '{8'hD0, 1'b0, 1'b0, 8'hD0, 4'b0001};
        vecs[11] = '{8'h80, 1'b0, 1'b0, 8'h80, 4'b1000};
        vecs[12] = '{8'h2C, 1'b0, 1'b0, 8'h2C, 4'b0010};
        vecs[13] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 4'b0010};
        vecs[14] = '{8'hC0, 1'b0, 1'b0, 8'hC0, 4'b0100};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        check("reset pad_latch", int'(pad_latch), 0);
        check("reset pad_clk", int'(pad_clk), 0);
        check("reset p_info", int'(p_info), 0);
        check("reset buttons", int'(buttons), 0);
        check("reset poll_done", int'(poll_done), 0);

        // Reset wins over a simultaneous frame_tick
        @(negedge clock);
        reset = 1'b1;
        frame_tick = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        frame_tick = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset+tick no latch", int'(pad_latch), 0);

        // Reset mid-poll aborts with Right held
        begin
            int dones;
            pressed = 8'h80;
            @(negedge clock);
            frame_tick = 1'b1;
            @(posedge clock);
            #1;
            frame_tick = 1'b0;
            repeat (29) @(posedge clock);
            #1;
            reset = 1'b1;
            @(posedge clock);
            #1;
            reset = 1'b0;
            check("abort pad_latch", int'(pad_latch), 0);
            check("abort pad_clk", int'(pad_clk), 0);
            check("abort p_info", int'(p_info), 0);
            check("abort buttons", int'(buttons), 0);
            dones = 0;
            for (int k = 0; k < 80; k++) begin
                @(posedge clock);
                #1;
                if (poll_done) dones++;
            end
            check("abort no poll_done", dones, 0);
            check("abort buttons later", int'(buttons), 0);
        end

        // Directed poll table
        for (int i = 0; i < 15; i++) begin
            int done_at;
            int lat_cnt;
            int hi_cnt;
            int pulses;
            logic prev_clk;
            done_at = -1;
            lat_cnt = 0;
            hi_cnt = 0;
            pulses = 0;
            prev_clk = 1'b0;
            pressed = vecs[i].pr;
            @(negedge clock);
            frame_tick = 1'b1;
            for (int n = 0; n <= 200; n++) begin
                @(posedge clock);
                #1;
                if (n == 0) frame_tick = 1'b0;
                if (vecs[i].retick && n == 20) frame_tick = 1'b1;
                if (n == 21) frame_tick = 1'b0;
                if (pad_latch) lat_cnt++;
                if (pad_clk) hi_cnt++;
                if (pad_clk && !prev_clk) pulses++;
                prev_clk = pad_clk;
                if (n == 40) check($sformatf("v%0d buttons mid-poll", i), int'(buttons),
                                   int'(prev_btn));
                if (poll_done) begin
                    done_at = n;
                    break;
                end
                if (n == 64 && vecs[i].dflt_v) dflt = 1'b1;
            end
            dflt = 1'b0;
            check($sformatf("v%0d latency", i), done_at, 16 * H + 1);
            check($sformatf("v%0d latch cycles", i), lat_cnt, 2 * H);
            check($sformatf("v%0d clk pulses", i), pulses, 7);
            check($sformatf("v%0d clk high cycles", i), hi_cnt, 7 * H);
            check($sformatf("v%0d buttons", i), int'(buttons), int'(vecs[i].exp_btn));
            check($sformatf("v%0d p_info", i), int'(p_info), int'(vecs[i].exp_pinfo));
            prev_btn = vecs[i].exp_btn;
            @(posedge clock);
            #1;
            check($sformatf("v%0d poll_done width", i), int'(poll_done), 0);
            if (vecs[i].retick) begin
                int extra;
                extra = 0;
                for (int k = 0; k < 80; k++) begin
                    @(posedge clock);
                    #1;
                    if (poll_done) extra++;
                end
                check($sformatf("v%0d retick ignored", i), extra, 0);
            end
            repeat (2) @(posedge clock);
        end

        // Random soak for the output invariants
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            frame_tick = ($urandom_range(0, 49) == 0);
            dflt = ($urandom_range(0, 19) == 0);
            pressed = 8'($urandom);
        end
        @(negedge clock);
        frame_tick = 1'b0;
        dflt = 1'b0;
        check("invariant violations", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
